trap_ctrl: RTL

Parametrised machine-mode trap controller for the pipelined RISC-V core. It arbitrates synchronous exceptions, `mret` and up to `NUM_IRQ` external interrupts. It owns the trap CSRs: mstatus, mie, mip, mtvec, mepc, mcause and mtval. It sequences CSR update, PC redirect and pipeline flush through a clocked FSM, with optional vectored interrupt dispatch. It sits beside the MEM stage and drives the IF PC mux and all four pipeline-register flushes.

---
 rtl/trap_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs, arbitrates exceptions, mret and
// interrupts, and sequences CSR save, PC redirect and pipeline flush.
module trap_ctrl #(
   parameter int          NUM_IRQ        = 4,
   parameter int          IRQ_CAUSE_BASE = 16,
   parameter bit          VECTORED_EN    = 1'b1,
   parameter int          HOLD_CYCLES    = 2,
   parameter logic [31:0] RESET_MTVEC    = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_illegal_inst,
   input  logic               i_ecall_m,
   input  logic               i_l_access_fault,
   input  logic               i_s_access_fault,
   input  logic               i_mret,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [31:0]        i_epc_cur,
   input  logic [31:0]        i_epc_next,
   input  logic [31:0]        i_fault_addr,
   input  logic               i_csr_we,
   input  logic [1:0]         i_csr_op,
   input  logic [11:0]        i_csr_addr,
   input  logic [31:0]        i_csr_wdata,
   output logic [31:0]        o_csr_rdata,
   output logic [31:0]        o_pc_redirect,
   output logic               o_redirect_valid,
   output logic               o_flush_fd,
   output logic               o_flush_de,
   output logic               o_flush_em,
   output logic               o_flush_mw,
   output logic               o_regwrite_cancel,
   output logic               o_busy
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;
   localparam logic [11:0] A_MIP     = 12'h344;

   localparam logic [30:0] IRQ_BASE    = 31'(IRQ_CAUSE_BASE);
   localparam int          HOLD_LAST_I = (HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0;
   localparam logic [3:0]  HOLD_LAST   = HOLD_LAST_I[3:0];
   localparam bit          HAS_HOLD    = (HOLD_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SAVE     = 2'd1,
      S_REDIRECT = 2'd2,
      S_HOLD     = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic [3:0]           r_hold_cnt;

   logic                 r_mstatus_mie;
   logic                 r_mstatus_mpie;
   logic [NUM_IRQ-1:0]   r_mie;
   logic [NUM_IRQ-1:0]   r_mip;
   logic [31:0]          r_mtvec;
   logic [31:0]          r_mepc;
   logic [31:0]          r_mcause;
   logic [31:0]          r_mtval;

   logic                 r_ev_mret;
   logic                 r_ev_irq;
   logic [31:0]          r_ev_cause;
   logic [31:0]          r_ev_epc;
   logic [31:0]          r_ev_tval;

   logic                 w_irq_found;
   logic [30:0]          w_irq_code;
   logic                 w_irq_take;
   logic                 w_ev_valid;
   logic                 w_ev_mret;
   logic                 w_ev_irq;
   logic [31:0]          w_ev_cause;
   logic [31:0]          w_ev_epc;
   logic [31:0]          w_ev_tval;

   logic [31:0]          w_rd_val;
   logic [31:0]          w_wr_val;
   logic [31:0]          w_mtvec_wr;
   logic                 w_sw_we;
   logic [31:0]          w_base;
   logic [31:0]          w_target;
   logic                 w_redirect;

   // lowest-index enabled interrupt line
   always_comb begin
      w_irq_found = 1'b0;
      w_irq_code  = 31'd0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (!w_irq_found && r_mip[i] && r_mie[i]) begin
            w_irq_found = 1'b1;
            w_irq_code  = IRQ_BASE + 31'(i);
         end else begin
            w_irq_found = w_irq_found;
         end
      end
   end

   assign w_irq_take = w_irq_found && r_mstatus_mie;

   always_comb begin
      w_ev_valid = 1'b1;
      w_ev_mret  = 1'b0;
      w_ev_irq   = 1'b0;
      w_ev_cause = 32'd0;
      w_ev_epc   = i_epc_cur;
      w_ev_tval  = 32'd0;
      if (i_illegal_inst) begin
         w_ev_cause = 32'd2;
      end else if (i_ecall_m) begin
         w_ev_cause = 32'd11;
      end else if (i_l_access_fault) begin
         w_ev_cause = 32'd5;
         w_ev_tval  = i_fault_addr;
      end else if (i_s_access_fault) begin
         w_ev_cause = 32'd7;
         w_ev_tval  = i_fault_addr;
      end else if (i_mret) begin
         w_ev_mret  = 1'b1;
      end else if (w_irq_take) begin
         w_ev_irq   = 1'b1;
         w_ev_cause = {1'b1, w_irq_code};
         w_ev_epc   = i_epc_next;
      end else begin
         w_ev_valid = 1'b0;
      end
   end

   always_comb begin
      case (i_csr_addr)
         A_MSTATUS: w_rd_val = {24'h00_0000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
         A_MIE:     w_rd_val = {{(32-NUM_IRQ){1'b0}}, r_mie};
         A_MTVEC:   w_rd_val = r_mtvec;
         A_MEPC:    w_rd_val = r_mepc;
         A_MCAUSE:  w_rd_val = r_mcause;
         A_MTVAL:   w_rd_val = r_mtval;
         A_MIP:     w_rd_val = {{(32-NUM_IRQ){1'b0}}, r_mip};
         default:   w_rd_val = 32'd0;
      endcase
   end

   assign o_csr_rdata = w_rd_val;

   always_comb begin
      case (i_csr_op)
         2'b01:   w_wr_val = i_csr_wdata;
         2'b10:   w_wr_val = w_rd_val | i_csr_wdata;
         2'b11:   w_wr_val = w_rd_val & ~i_csr_wdata;
         default: w_wr_val = w_rd_val;
      endcase
   end

   // an unsupported mtvec mode keeps the previous mode bits
   assign w_mtvec_wr = {w_wr_val[31:2], (w_wr_val[1] ? r_mtvec[1:0] : w_wr_val[1:0])};
   assign w_sw_we    = i_csr_we && (i_csr_op != 2'b00) && (r_state == S_IDLE) && !w_ev_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_redirect = 1'b0;
      o_busy     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ev_valid) begin
               w_state_nx = S_SAVE;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_SAVE: begin
            o_busy     = 1'b1;
            w_state_nx = S_REDIRECT;
         end
         S_REDIRECT: begin
            o_busy     = 1'b1;
            w_redirect = 1'b1;
            if (HAS_HOLD) begin
               w_state_nx = S_HOLD;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_HOLD: begin
            o_busy = 1'b1;
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nx = S_IDLE;
            end else begin
               w_state_nx = S_HOLD;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt <= 4'd0;
      end else if (r_state == S_HOLD) begin
         r_hold_cnt <= r_hold_cnt + 4'd1;
      end else begin
         r_hold_cnt <= 4'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mip <= {NUM_IRQ{1'b0}};
      end else begin
         r_mip <= i_irq;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ev_mret  <= 1'b0;
         r_ev_irq   <= 1'b0;
         r_ev_cause <= 32'd0;
         r_ev_epc   <= 32'd0;
         r_ev_tval  <= 32'd0;
      end else if ((r_state == S_IDLE) && w_ev_valid) begin
         r_ev_mret  <= w_ev_mret;
         r_ev_irq   <= w_ev_irq;
         r_ev_cause <= w_ev_cause;
         r_ev_epc   <= w_ev_epc;
         r_ev_tval  <= w_ev_tval;
      end else begin
         r_ev_mret  <= r_ev_mret;
         r_ev_irq   <= r_ev_irq;
         r_ev_cause <= r_ev_cause;
         r_ev_epc   <= r_ev_epc;
         r_ev_tval  <= r_ev_tval;
      end
   end

   // trap save has precedence; software writes only land while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mstatus_mie  <= 1'b1;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= {NUM_IRQ{1'b0}};
         r_mtvec        <= RESET_MTVEC;
         r_mepc         <= 32'd0;
         r_mcause       <= 32'd0;
         r_mtval        <= 32'd0;
      end else if (r_state == S_SAVE) begin
         if (r_ev_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else begin
            r_mepc         <= {r_ev_epc[31:2], 2'b00};
            r_mcause       <= r_ev_cause;
            r_mtval        <= r_ev_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end
      end else if (w_sw_we) begin
         case (i_csr_addr)
            A_MSTATUS: begin
               r_mstatus_mie  <= w_wr_val[3];
               r_mstatus_mpie <= w_wr_val[7];
            end
            A_MIE:    r_mie    <= w_wr_val[NUM_IRQ-1:0];
            A_MTVEC:  r_mtvec  <= w_mtvec_wr;
            A_MEPC:   r_mepc   <= {w_wr_val[31:2], 2'b00};
            A_MCAUSE: r_mcause <= w_wr_val;
            A_MTVAL:  r_mtval  <= w_wr_val;
            default: begin
            end
         endcase
      end else begin
         r_mstatus_mie <= r_mstatus_mie;
      end
   end

   always_comb begin
      w_base = {r_mtvec[31:2], 2'b00};
      if (r_ev_mret) begin
         w_target = r_mepc;
      end else if (VECTORED_EN && r_ev_irq && (r_mtvec[1:0] == 2'b01)) begin
         w_target = w_base + {r_ev_cause[29:0], 2'b00};
      end else begin
         w_target = w_base;
      end
   end

   assign o_redirect_valid  = w_redirect;
   assign o_pc_redirect     = w_redirect ? w_target : 32'd0;
   assign o_flush_fd        = w_redirect;
   assign o_flush_de        = w_redirect;
   assign o_flush_em        = w_redirect;
   assign o_flush_mw        = w_redirect;
   assign o_regwrite_cancel = w_redirect;

endmodule
